mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Round-robin arbiter that shares one memory_unit command port among N requesters: the traversal engine, the execute unit and the allocator front-end. It serialises requests, drives the memory_unit func/execute/address/write_data handshake, and returns read_data or free_addr to the winning requester. A watchdog flags a memory unit that never becomes ready again, for example one stuck in garbage collect.

Parameters:
N, 3, number of requesters (2..8)
ADDR_W, 10, memory address width (matches memory_addr_width)
DATA_W, 64, memory word width (matches memory_data_width)
TIMEOUT, 1023, max cycles in BUSY before the hang flag is raised; counter width is clog2(TIMEOUT+1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  N  per-requester request; held stable with its fields until that requester's rsp_valid bit pulses
req_func  in  2*N  func per requester; slice i is [2i+1:2i]
req_addr  in  ADDR_W*N  address per requester
req_wdata  in  DATA_W*N  write data per requester, or the cell count for GET_FREE
rsp_valid  out  N  one-cycle completion pulse, one-hot
rsp_rdata  out  DATA_W  read_data captured at completion
rsp_free_addr  out  ADDR_W  free_addr captured at completion
grant_id  out  clog2(N)  index of the current or last granted requester
busy  out  1  high in every state except IDLE
hang  out  1  sticky watchdog flag
mem_func  out  2  to memory_unit func
mem_execute  out  1  to memory_unit execute
mem_address  out  ADDR_W  to memory_unit address
mem_write_data  out  DATA_W  to memory_unit write_data
mem_is_ready  in  1  from memory_unit is_ready
mem_read_data  in  DATA_W  from memory_unit read_data
mem_free_addr  in  ADDR_W  from memory_unit free_addr

Behaviour:
- Reset (rst low, async): all outputs go to 0.
  - State goes to IDLE.
  - The round-robin pointer goes to N-1, so requester 0 has first priority.
  - Watchdog counter goes to 0.
- All outputs are registered.
- The memory_unit shares rst, so a reset mid-operation aborts both blocks cleanly. In-flight requests are not replayed; requesters re-present them.
- IDLE:
  - If mem_is_ready=1 and any req_valid bit is set, pick the first set bit searching from pointer+1 upward, wrapping modulo N.
  - Latch that requester's func, addr and wdata into mem_func, mem_address and mem_write_data. Set grant_id and the pointer to the winner. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_execute=1 for exactly one cycle; go to BLANK.
  - The memory unit samples the command on this edge.
- BLANK:
  - mem_execute=0. Ignore mem_is_ready for one cycle; the memory unit's internal ready is clearing. Go to BUSY.
- BUSY:
  - Wait for mem_is_ready=1. Then capture mem_read_data into rsp_rdata and mem_free_addr into rsp_free_addr, and go to RESP.
  - Both capture registers are updated for every func; requesters use the relevant one.
  - The watchdog counts each BUSY cycle. When the count reaches TIMEOUT with ready still low: set hang=1 and go to HANG.
- RESP:
  - rsp_valid[grant_id]=1 for one cycle.
  - Clear the watchdog and go to IDLE.
  - The next grant is no earlier than the cycle after RESP. The requester must drop or change req_valid by then.
- HANG:
  - Terminal until reset. No grants; busy=1, hang=1.
- Command path latency: minimum 5 cycles from req_valid sampled in IDLE to rsp_valid, for GET_FREE.
  - IDLE→ISSUE→BLANK→BUSY(1)→RESP.
  - Reads and writes add the memory unit's 2 extra states.
- The mem_* command fields hold their latched values from ISSUE until the next grant. They never change while a command is outstanding.
- A requester dropping req_valid before its response is a protocol violation. The transaction still completes and rsp_valid still pulses.
- Requests arriving while busy wait; there is no queueing beyond the held req_valid.
- With all N requesters continuously valid, grants rotate 0,1,2,0,… Each requester waits at most N-1 transactions.

Decomposition:
- Func encodings (GET_CONTENTS=0, SET_CONTENTS=1, GET_FREE=2) and the address/data widths come from the shared memory_unit header; no new constants are added there.
- Arbiter state encodings are local parameters.
- One combinational sub-module, rr_pick, takes N-bit requests and the pointer and returns a found flag and the winner index. It is reusable by other shared-resource controllers.

Test Plan:
- Single read: memory address 5 preloaded with 0xABC, requester 1 issues GET_CONTENTS addr 5 → exactly one mem_execute pulse with mem_address=5; rsp_valid=3'b010 with rsp_rdata=0xABC; grant_id=1.
- Write then read: requester 0 issues SET_CONTENTS addr 7 data 0x55, then GET_CONTENTS addr 7 → two responses on bit 0, the second with rsp_rdata=0x55.
- Contention: all three requesters valid from reset, each re-requesting after its response → grant order 0,1,2,0,1,2; no overlapping mem_execute pulses.
- GET_FREE: memory word 0 holds 100, requester 2 sends wdata=2 twice → rsp_free_addr=100 then 102.
- Watchdog: mem_is_ready is forced low after ISSUE → hang=1 after exactly TIMEOUT BUSY cycles; no later grant even with req_valid set; rst low clears hang and returns to IDLE.
- Async reset mid-BUSY → all outputs 0 immediately and pointer back to N-1; after release, the first grant goes to requester 0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: memory_unit func codes and widths,
// plus the arbiter FSM state encoding.
package mem_arbiter_pkg;

  // memory_unit command port widths
  localparam int MEM_ADDR_W = 10;
  localparam int MEM_DATA_W = 64;

  // memory_unit func encodings
  localparam logic [1:0] FUNC_GET_CONTENTS = 2'd0;
  localparam logic [1:0] FUNC_SET_CONTENTS = 2'd1;
  localparam logic [1:0] FUNC_GET_FREE     = 2'd2;

  // Arbiter FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BLANK = 3'd2,
    ST_BUSY  = 3'd3,
    ST_RESP  = 3'd4,
    ST_HANG  = 3'd5
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request strictly
// after ptr_i, wrapping around to ptr_i itself last.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  // Two passes: indices above the pointer first, then the wrapped range.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found_o && req_i[i] && (IW'(i) > ptr_i)) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found_o && req_i[i] && (IW'(i) <= ptr_i)) begin
        found_o = 1'b1;
        idx_o   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory_unit command port among N requesters.
// Every output is a flop; the FSM walks IDLE->ISSUE->BLANK->BUSY->RESP and
// parks in HANG if the memory unit never returns ready.
// Handshake: a requester holds req_valid and its fields stable until its
// one-cycle rsp_valid pulse; towards memory, mem_execute pulses once while
// mem_is_ready is high and the command fields then stay frozen until the
// next grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int N       = 3,
  parameter int ADDR_W  = MEM_ADDR_W,
  parameter int DATA_W  = MEM_DATA_W,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req_valid,
  input  logic [2*N-1:0]        req_func,
  input  logic [ADDR_W*N-1:0]   req_addr,
  input  logic [DATA_W*N-1:0]   req_wdata,
  output logic [N-1:0]          rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     rsp_free_addr,
  output logic [$clog2(N)-1:0]  grant_id,
  output logic                  busy,
  output logic                  hang,
  output logic [1:0]            mem_func,
  output logic                  mem_execute,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W-1:0]     mem_write_data,
  input  logic                  mem_is_ready,
  input  logic [DATA_W-1:0]     mem_read_data,
  input  logic [ADDR_W-1:0]     mem_free_addr
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  // Per-requester views of the flattened request buses
  logic [1:0]        func_a  [N];
  logic [ADDR_W-1:0] addr_a  [N];
  logic [DATA_W-1:0] wdata_a [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign func_a[g]  = req_func[2*g +: 2];
    assign addr_a[g]  = req_addr[ADDR_W*g +: ADDR_W];
    assign wdata_a[g] = req_wdata[DATA_W*g +: DATA_W];
  end

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [1:0]        func_q, func_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              exec_q, exec_d;
  logic              busy_q, busy_d;
  logic              hang_q, hang_d;
  logic [N-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] free_q, free_d;
  logic [CW-1:0]     wd_q, wd_d;

  logic              pick_found;
  logic [IW-1:0]     pick_idx;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Next-state, command latch, response capture and watchdog
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    func_d  = func_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    hang_d  = hang_q;
    rdata_d = rdata_q;
    free_d  = free_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_is_ready && pick_found) begin
          grant_d = pick_idx;
          ptr_d   = pick_idx;
          func_d  = func_a[pick_idx];
          addr_d  = addr_a[pick_idx];
          wdata_d = wdata_a[pick_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_BLANK;
      // Memory ready is still falling here, so it is not looked at.
      ST_BLANK: state_d = ST_BUSY;
      ST_BUSY: begin
        if (mem_is_ready) begin
          rdata_d = mem_read_data;
          free_d  = mem_free_addr;
          state_d = ST_RESP;
        end else if (wd_q == CW'(TIMEOUT - 1)) begin
          hang_d  = 1'b1;
          state_d = ST_HANG;
        end else begin
          wd_d = wd_q + CW'(1);
        end
      end
      ST_RESP: begin
        wd_d    = '0;
        state_d = ST_IDLE;
      end
      ST_HANG: state_d = ST_HANG;
      default: state_d = ST_IDLE;
    endcase
    // Pulse-style outputs are decoded from the next state so they register
    exec_d      = (state_d == ST_ISSUE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP) ? (N'(1) << grant_q) : '0;
  end

  // State and output registers, async active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IW'(N - 1);
      grant_q     <= '0;
      func_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      exec_q      <= 1'b0;
      busy_q      <= 1'b0;
      hang_q      <= 1'b0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      free_q      <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      func_q      <= func_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      exec_q      <= exec_d;
      busy_q      <= busy_d;
      hang_q      <= hang_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      free_q      <= free_d;
      wd_q        <= wd_d;
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rdata_q;
  assign rsp_free_addr  = free_q;
  assign grant_id       = grant_q;
  assign busy           = busy_q;
  assign hang           = hang_q;
  assign mem_func       = func_q;
  assign mem_execute    = exec_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory_unit model and a
// response scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int T  = 16;
  localparam int EW = 4 + 1 + 1 + DW + AW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [2*N-1:0]  req_func  = '0;
  logic [AW*N-1:0] req_addr  = '0;
  logic [DW*N-1:0] req_wdata = '0;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   rsp_free_addr;
  logic [1:0]      grant_id;
  logic            busy, hang;
  logic [1:0]      mem_func;
  logic            mem_execute;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_write_data;
  logic            mem_is_ready;
  logic [DW-1:0]   mem_read_data;
  logic [AW-1:0]   mem_free_addr;

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_func(req_func), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_free_addr(rsp_free_addr),
    .grant_id(grant_id), .busy(busy), .hang(hang),
    .mem_func(mem_func), .mem_execute(mem_execute), .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_is_ready(mem_is_ready), .mem_read_data(mem_read_data),
    .mem_free_addr(mem_free_addr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory_unit model ----------------
  // Ready drops on the execute edge; GET_FREE returns after 1 cycle, reads
  // and writes after 3. mem_stuck keeps ready low forever.
  logic [DW-1:0] mem_model [1024];
  logic          mem_stuck = 1'b0;
  int            mem_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_is_ready  <= 1'b1;
      mem_read_data <= '0;
      mem_free_addr <= '0;
      mem_cnt       <= 0;
    end else if (mem_execute) begin
      mem_is_ready <= 1'b0;
      mem_cnt      <= (mem_func == FUNC_GET_FREE) ? 1 : 3;
      case (mem_func)
        FUNC_GET_CONTENTS: mem_read_data <= mem_model[mem_address];
        FUNC_SET_CONTENTS: mem_model[mem_address] <= mem_write_data;
        FUNC_GET_FREE: begin
          mem_free_addr <= mem_model[0][AW-1:0];
          mem_model[0]  <= mem_model[0] + mem_write_data;
        end
        default: ;
      endcase
    end else if (mem_cnt > 0) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1 && !mem_stuck) mem_is_ready <= 1'b1;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entry: {id, check_rdata, check_free, rdata, free_addr}
  logic [EW-1:0] exp_q[$];

  task automatic exp_push(input int id, input logic cr, input logic [DW-1:0] rd,
                          input logic cf, input logic [AW-1:0] fa);
    exp_q.push_back({4'(id), cr, cf, rd, fa});
  endtask

  logic [EW-1:0] mon_e;
  always @(negedge clk) begin
    if (rst && rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rsp_valid 0x%0h expected none", rsp_valid);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_onehot", 64'(rsp_valid), 64'(1) << mon_e[EW-1 -: 4]);
        check("grant_id", 64'(grant_id), 64'(mon_e[EW-1 -: 4]));
        if (mon_e[EW-5]) check("rsp_rdata", rsp_rdata, mon_e[AW +: DW]);
        if (mon_e[EW-6]) check("rsp_free_addr", 64'(rsp_free_addr), 64'(mon_e[AW-1:0]));
      end
    end
  end

  // Execute-pulse monitor: counts commands and flags back-to-back pulses
  int            exec_cnt = 0;
  logic          exec_prev = 1'b0;
  logic [AW-1:0] last_exec_addr = '0;
  always @(negedge clk) begin
    if (mem_execute) begin
      exec_cnt++;
      last_exec_addr = mem_address;
      check("exec_single_cycle", 64'(exec_prev), 64'd0);
    end
    exec_prev = mem_execute;
  end

  // ---------------- driver ----------------
  task automatic drive(input int id, input logic [1:0] f, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    int n;
    req_func[2*id +: 2]   = f;
    req_addr[AW*id +: AW] = a;
    req_wdata[DW*id +: DW] = wd;
    req_valid[id] = 1'b1;
    n = 0;
    while (!rsp_valid[id] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid[id]) begin
      tests++;
      fails++;
      $display("FAIL rsp_timeout: got no response for requester %0d expected one", id);
    end
    req_valid[id] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_exec(output int n);
    n = 0;
    while (!mem_execute && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("exec_seen", 64'(mem_execute), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    check({tag, "_rsp_free"}, 64'(rsp_free_addr), 64'd0);
    check({tag, "_grant_id"}, 64'(grant_id), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_hang"}, 64'(hang), 64'd0);
    check({tag, "_mem_func"}, 64'(mem_func), 64'd0);
    check({tag, "_mem_exec"}, 64'(mem_execute), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_address), 64'd0);
    check({tag, "_mem_wdata"}, mem_write_data, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int e0;
    for (int i = 0; i < 1024; i++) mem_model[i] = '0;
    mem_model[5]  = 64'hABC;
    mem_model[0]  = 64'd100;
    mem_model[20] = 64'h100;
    mem_model[21] = 64'h101;
    mem_model[22] = 64'h102;
    mem_model[30] = 64'h77;

    // reset
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // single read by requester 1
    e0 = exec_cnt;
    exp_push(1, 1'b1, 64'hABC, 1'b0, '0);
    drive(1, FUNC_GET_CONTENTS, 10'd5, 64'd0);
    check("read_exec_count", 64'(exec_cnt - e0), 64'd1);
    check("read_exec_addr", 64'(last_exec_addr), 64'd5);

    // write then read by requester 0
    exp_push(0, 1'b0, '0, 1'b0, '0);
    drive(0, FUNC_SET_CONTENTS, 10'd7, 64'h55);
    exp_push(0, 1'b1, 64'h55, 1'b0, '0);
    drive(0, FUNC_GET_CONTENTS, 10'd7, 64'd0);

    // GET_FREE twice by requester 2
    exp_push(2, 1'b0, '0, 1'b1, 10'd100);
    drive(2, FUNC_GET_FREE, 10'd0, 64'd2);
    exp_push(2, 1'b0, '0, 1'b1, 10'd102);
    drive(2, FUNC_GET_FREE, 10'd0, 64'd2);

    // contention: all three valid together, each re-requesting once
    e0 = exec_cnt;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) exp_push(i, 1'b1, 64'h100 + 64'(i), 1'b0, '0);
    fork
      begin drive(0, FUNC_GET_CONTENTS, 10'd20, 64'd0); drive(0, FUNC_GET_CONTENTS, 10'd20, 64'd0); end
      begin drive(1, FUNC_GET_CONTENTS, 10'd21, 64'd0); drive(1, FUNC_GET_CONTENTS, 10'd21, 64'd0); end
      begin drive(2, FUNC_GET_CONTENTS, 10'd22, 64'd0); drive(2, FUNC_GET_CONTENTS, 10'd22, 64'd0); end
    join
    check("contention_exec_count", 64'(exec_cnt - e0), 64'd6);

    // watchdog: memory never returns ready
    mem_stuck = 1'b1;
    req_func[1:0] = FUNC_GET_CONTENTS;
    req_addr[AW-1:0] = 10'd9;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    wait_exec(n);
    n = 0;
    while (!hang && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("hang_latency", 64'(n), 64'(T + 2));
    e0 = exec_cnt;
    repeat (10) @(posedge clk);
    #1;
    check("hang_no_grant", 64'(exec_cnt - e0), 64'd0);
    check("hang_sticky", 64'(hang), 64'd1);
    check("hang_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    req_valid = '0;
    #1;
    check("hang_cleared", 64'(hang), 64'd0);
    check("hang_busy_cleared", 64'(busy), 64'd0);
    mem_stuck = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // async reset mid-BUSY after granting requester 0
    req_func[1:0] = FUNC_GET_CONTENTS;
    req_addr[AW-1:0] = 10'd30;
    req_valid[0] = 1'b1;
    wait_exec(n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midbusy_busy", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1 check_all_zero("async_reset");
    req_valid = '0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    exp_push(0, 1'b1, 64'h77, 1'b0, '0);
    exp_push(1, 1'b1, 64'h101, 1'b0, '0);
    fork
      drive(0, FUNC_GET_CONTENTS, 10'd30, 64'd0);
      drive(1, FUNC_GET_CONTENTS, 10'd21, 64'd0);
    join

    repeat (4) @(posedge clk);
    #1 check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
